// File: rtl/fetch_pkg.sv
// Shared types for the LemonPC instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned FETCH_XLEN = 64;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [INST_W-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; no write-to-read bypass.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         ENTRY_T = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ENTRY_T                   push_data,
    input  logic                     pop,
    output ENTRY_T                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ENTRY_T          mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_q] <= push_data;
            end
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Handshaked instruction fetch front end with redirect flush.
// Optional FETCH_UNIT_PERF_EN adds dequeue and request-stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0]       perf_inst_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned    CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_RESET = XLEN'(RESET_PC);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CW-1:0]     count;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   redirect_tgt;
    entry_t            push_entry;
    entry_t            head;
    logic              unused_redirect_lsbs;

    assign imem_req_valid = (state_q == REQ) && (count < CW'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = inst_valid && inst_ready;
    assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;

        unique case (state_q)
            REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides everything: anything still in flight after this
        // edge belongs to the old stream and must be drained, not delivered.
        if (redirect_valid) begin
            pc_d = redirect_tgt;
            push = 1'b0;
            if ((state_q == REQ && req_fire) ||
                (state_q != REQ && !imem_resp_valid)) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= PC_RESET;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign push_entry.pc   = req_pc_q;
    assign push_entry.inst = imem_resp_data;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop)                              perf_inst_q  <= perf_inst_q + 32'd1;
            if (imem_req_valid && !imem_req_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_inst_cnt  = perf_inst_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] KEY    = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
`ifdef FETCH_UNIT_PERF_EN
        ,
        .perf_inst_cnt   (perf_inst_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ KEY;
    endfunction

    // Memory: one request at a time, answers 'lat' cycles after the cycle following acceptance.
    int unsigned lat = 0;
    logic        mem_pend;
    int unsigned mem_cnt;
    logic [63:0] mem_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (mem_pend) begin
            if (mem_cnt == 0) mem_pend <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_pend <= 1'b1;
            mem_cnt  <= lat;
            mem_addr <= imem_req_addr;
        end
    end

    assign imem_resp_valid = mem_pend && (mem_cnt == 0);
    assign imem_resp_data  = inst_of(mem_addr);

    // Reference model: the instruction stream as decode should see it.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_req_pc = '0;
    bit          m_pend = 0;
    bit          m_live = 0;
    logic [31:0] m_inst_cnt = '0;
    logic [31:0] m_stall_cnt = '0;

    task automatic model_step();
        bit can_req, hs, pop;
        if (rst) begin
            mq.delete();
            m_pc = RST_PC;
            m_pend = 0;
            m_live = 0;
            m_inst_cnt = '0;
            m_stall_cnt = '0;
            return;
        end
        can_req = !m_pend && (mq.size() < DEPTH);
        hs      = can_req && imem_req_ready;
        pop     = (mq.size() != 0) && inst_ready;
        if (pop) m_inst_cnt = m_inst_cnt + 1;
        if (can_req && !imem_req_ready) m_stall_cnt = m_stall_cnt + 1;
        if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_pc[63:2], 2'b00};
            if (m_pend && imem_resp_valid) m_pend = 0;
            m_live = 0;
            if (hs) m_pend = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend && imem_resp_valid) begin
                m_pend = 0;
                if (m_live) mq.push_back('{pc: m_req_pc, d: inst_of(m_req_pc)});
            end
            if (hs) begin
                m_pend = 1;
                m_live = 1;
                m_req_pc = m_pc;
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("req_valid", imem_req_valid, !m_pend && (mq.size() < DEPTH));
            if (!m_pend && (mq.size() < DEPTH)) chk("req_addr", imem_req_addr, m_pc);
            chk("inst_valid", inst_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst", inst, mq[0].d);
            end
`ifdef FETCH_UNIT_PERF_EN
            chk("perf_inst", perf_inst_cnt, m_inst_cnt);
            chk("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] stall_base;
`endif

    initial begin
        step(3);
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
`ifdef FETCH_UNIT_PERF_EN
        chk("rst_perf_inst", perf_inst_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
        rst = 1'b0;

        // Zero-wait memory: deliveries at cycles 2, 4, 6.
        step(1);
        chk("zw_c1_valid", inst_valid, 0);
        step(1);
        chk("zw_c2_valid", inst_valid, 1);
        chk("zw_c2_pc", inst_pc, 64'h8000_0000);
        chk("zw_c2_inst", inst, 32'h9357_9BDF);
        step(2);
        chk("zw_c4_pc", inst_pc, 64'h8000_0004);
        step(2);
        chk("zw_c6_pc", inst_pc, 64'h8000_0008);

        // Decode backpressure fills the buffer.
        inst_ready = 1'b0;
        step(20);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_inst_valid", inst_valid, 1);
        chk("bp_head_pc", inst_pc, 64'h8000_0008);
        chk("bp_next_addr", imem_req_addr, 64'h8000_0018);
        inst_ready = 1'b1;
        step(1); chk("bp_drain0", inst_pc, 64'h8000_000C);
        step(1); chk("bp_drain1", inst_pc, 64'h8000_0010);
        step(1); chk("bp_drain2", inst_pc, 64'h8000_0014);
        step(1); chk("bp_drain3", inst_pc, 64'h8000_0018);
        step(6);

        // Memory refuses requests for 5 cycles.
        imem_req_ready = 1'b0;
        for (int k = 0; k < 40 && !imem_req_valid; k++) step();
        chk("stall_wait", imem_req_valid, 1);
`ifdef FETCH_UNIT_PERF_EN
        stall_base = perf_stall_cnt;
`endif
        step(5);
        imem_req_ready = 1'b1;
`ifdef FETCH_UNIT_PERF_EN
        chk("stall_cnt5", perf_stall_cnt - stall_base, 32'd5);
`endif
        step(6);

        // Redirect while a slow response is outstanding.
        lat = 2;
        for (int k = 0; k < 40 && !(mem_pend && mem_cnt != 0); k++) step();
        chk("rdw_wait", mem_pend && mem_cnt != 0, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        step(1);
        redirect_valid = 1'b0;
        lat = 0;
        chk("rdw_flushed", inst_valid, 0);
        chk("rdw_draining", imem_req_valid, 0);
        for (int k = 0; k < 40 && !imem_req_valid; k++) step();
        chk("rdw_req_wait", imem_req_valid, 1);
        chk("rdw_req_addr", imem_req_addr, 64'h8000_1000);
        for (int k = 0; k < 40 && !inst_valid; k++) step();
        chk("rdw_inst_wait", inst_valid, 1);
        chk("rdw_first_pc", inst_pc, 64'h8000_1000);
        chk("rdw_first_inst", inst, 32'h9357_8BDF);
        step(4);

        // Redirect in the same cycle as a response.
        for (int k = 0; k < 40 && !imem_resp_valid; k++) step();
        chk("rdc_wait", imem_resp_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        step(1);
        redirect_valid = 1'b0;
        chk("rdc_req_valid", imem_req_valid, 1);
        chk("rdc_req_addr", imem_req_addr, 64'h8000_2000);
        chk("rdc_flushed", inst_valid, 0);
        for (int k = 0; k < 40 && !inst_valid; k++) step();
        chk("rdc_inst_wait", inst_valid, 1);
        chk("rdc_first_pc", inst_pc, 64'h8000_2000);
        step(4);

        // Reset mid-WAIT with two entries buffered.
        inst_ready = 1'b0;
        lat = 2;
        for (int k = 0; k < 60 && !(mem_pend && mem_cnt != 0 && mq.size() == 2); k++) step();
        chk("rst2_wait", mem_pend && mem_cnt != 0 && mq.size() == 2, 1);
        rst = 1'b1;
        #1;
        chk("rst2_inst_valid", inst_valid, 0);
        chk("rst2_req_valid", imem_req_valid, 1);
        chk("rst2_req_addr", imem_req_addr, RST_PC);
        lat = 0;
        inst_ready = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        chk("rst2_restart_valid", inst_valid, 1);
        chk("rst2_restart_pc", inst_pc, 64'h8000_0000);
        step(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit for the LemonPC core. It replaces the single-cycle `pc <= pc + 4` fetch with a handshaked front end. The unit drives a valid/ready instruction-memory request port, buffers returned instruction words in a small FIFO, and presents them to decode with their PC under a valid/ready handshake. Redirects from execute (branch/jump/trap) flush the buffer and discard any in-flight response.

## Interface
Parameters:
- `XLEN`, 64: PC and address width.
- `RESET_PC`, `64'h0000_0000_8000_0000`: PC after reset, truncated to XLEN.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address; always 4-byte aligned.
- `imem_resp_valid`  in  1  response valid; always accepted, no ready signal.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  redirect the fetch stream.
- `redirect_pc`  in  XLEN  new PC; bits [1:0] are ignored and treated as 0.
- `inst_valid`  out  1  head of FIFO is valid.
- `inst_ready`  in  1  decode consumes the head.
- `inst`  out  32  instruction word.
- `inst_pc`  out  XLEN  PC of `inst`.

## Operation
FSM states:
- `REQ`: issuing a request. `imem_req_valid` = (`count` < FIFO_DEPTH).
- `WAIT`: one request outstanding.
- `DRAIN`: one request outstanding whose response must be discarded.

Transitions and rules:
- Reset puts the FSM in `REQ`, sets `pc` = RESET_PC, and sets `count` = 0.
- `REQ`: when `imem_req_valid && imem_req_ready`, latch `req_pc` = `pc`, set `pc` += 4, and go to `WAIT`.
- `WAIT`: on `imem_resp_valid`, enqueue {`req_pc`, `imem_resp_data`} and go to `REQ`.
- `DRAIN`: on `imem_resp_valid`, drop the data and go to `REQ`.
- At most one request is outstanding. A request is issued only when `count` < FIFO_DEPTH, so an enqueue always has room.
- Dequeue occurs on `inst_valid && inst_ready`. Enqueue and dequeue may happen in the same cycle; `count` is then unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. `count` is log2(FIFO_DEPTH)+1 bits.
- PC arithmetic is modulo 2^XLEN; wrap-around is silent.

Redirect (highest priority, takes effect on the edge where `redirect_valid` = 1):
- FIFO is flushed (`count` = 0) and `pc` = {`redirect_pc`[XLEN-1:2], 2'b00}.
- In `WAIT` without a response, or in `REQ` with a handshake this cycle: go to `DRAIN`.
- In `WAIT` with `imem_resp_valid` the same cycle: the response is dropped; go to `REQ`.
- In `DRAIN`: stay in `DRAIN`, or go to `REQ` if the response arrives this cycle.
- In `REQ` without a handshake: stay in `REQ`. The unaccepted address changes to the redirect target next cycle, and memory must tolerate this.
- A dequeue in the same cycle as a redirect is still counted as consumed by decode.

## Timing
Reset values:
- `imem_req_valid` = 1, `imem_req_addr` = RESET_PC.
- `inst_valid` = 0; `inst` and `inst_pc` = 0.

Latency and throughput:
- Request handshake at edge N, response at cycle N+1 (earliest), `inst_valid` at cycle N+2.
- `imem_req_valid` rises in the cycle after a `WAIT` response.
- Peak throughput is one instruction every 2 cycles.
- `inst_valid` goes low in the cycle after a redirect; first new instruction appears at redirect + 3 cycles at the earliest.
- Reset mid-operation abandons any outstanding request. Memory must itself be reset by the same `rst`.

## Configuration
- `FETCH_UNIT_PERF_EN` defined: adds two ports, both reset to 0 and wrapping at 2^32.
  - `perf_inst_cnt` out 32: counts dequeues.
  - `perf_stall_cnt` out 32: counts cycles with `imem_req_valid && !imem_req_ready`.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e` enum {REQ, WAIT, DRAIN}.
  - `fetch_entry_t` struct {pc, inst}, parametrised via XLEN default 64.
  - `INST_W` = 32.
- Sub-module `fetch_fifo`:
  - Generic synchronous FIFO of `fetch_entry_t` with `flush`, `push`, `pop`, `count`.
  - No bypass: a pushed entry is visible the next cycle.

## Test plan
- Reset, zero-wait memory (ready = 1, response next cycle) → `inst_pc` sequence 0x80000000, 0x80000004, 0x80000008 with `inst_valid` first high at cycle 2 after reset release.
- `inst_ready` = 0 for 20 cycles → exactly 4 entries buffered, then `imem_req_valid` = 0. Releasing `inst_ready` drains all 4 in order with no loss or duplicates.
- `imem_req_ready` held low 5 cycles → `imem_req_addr` stable, `perf_stall_cnt` = 5 (with `FETCH_UNIT_PERF_EN`).
- Redirect to 0x80001002 while in `WAIT` → next delayed response is discarded, next request addr = 0x80001000, and the first delivered `inst_pc` = 0x80001000.
- Redirect coincident with `imem_resp_valid` → that word is never delivered; next request is issued the following cycle at the target PC.
- `rst` pulsed mid-`WAIT` with 2 entries buffered → `inst_valid` = 0 immediately and fetch restarts at 0x80000000.
